dir_rot_sample_gen: RTL and testbench



---
 rtl/dir_rot_sample_gen.sv | 147 ++++++++++++++
 tb/tb_dir_rot_sample_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dir_rot_sample_gen.sv
// Rotated sample-offset generator: streams GRIDxGRID (u,v) offsets rotated by a 5-bit orientation bin.
// Latency: first sample valid 2 cycles after the accepted start, then one sample per cycle.
// Backpressure: out_valid & !out_ready freezes the grid counter and both pipeline stages.
module dir_rot_sample_gen #(
    parameter int GRID = 16,
    parameter int OW   = $clog2(GRID) + 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [4:0]                   dir,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OW-1:0]         out_x,
    output logic signed [OW-1:0]         out_y,
    output logic [$clog2(GRID*GRID)-1:0] out_idx,
    output logic                         done
);
    localparam int UW = $clog2(GRID);
    localparam int IW = $clog2(GRID * GRID);
    localparam int PW = UW + 9;
    localparam int SW = PW + 1;
    localparam logic [IW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic                done_nxt;
    logic                load, adv, gen;
    logic [IW-1:0]       idx_r;
    logic signed [UW-1:0] u, v;
    logic [7:0]          ca, sa;
    logic signed [8:0]   cos_nxt, sin_nxt, cos_r, sin_r;
    logic                s1_vld;
    logic [IW-1:0]       s1_idx;
    logic signed [PW-1:0] s1_ucos, s1_vsin, s1_usin, s1_vcos;
    logic signed [SW-1:0] sum_x, sum_y;

    function automatic logic [7:0] cos_tab(input logic [3:0] k);
        case (k)
            4'd0:    cos_tab = 8'd128;
            4'd1:    cos_tab = 8'd126;
            4'd2:    cos_tab = 8'd118;
            4'd3:    cos_tab = 8'd106;
            4'd4:    cos_tab = 8'd91;
            4'd5:    cos_tab = 8'd71;
            4'd6:    cos_tab = 8'd49;
            4'd7:    cos_tab = 8'd25;
            default: cos_tab = 8'd0;
        endcase
    endfunction

    // Quadrant folding of the quarter-wave table into signed cos/sin.
    always_comb begin
        ca = cos_tab({1'b0, dir[2:0]});
        sa = cos_tab(4'd8 - {1'b0, dir[2:0]});
        cos_nxt = {1'b0, ca};
        sin_nxt = {1'b0, sa};
        case (dir[4:3])
            2'd1: begin cos_nxt = -{1'b0, sa}; sin_nxt =  {1'b0, ca}; end
            2'd2: begin cos_nxt = -{1'b0, ca}; sin_nxt = -{1'b0, sa}; end
            2'd3: begin cos_nxt =  {1'b0, sa}; sin_nxt = -{1'b0, ca}; end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign load = (state == IDLE) && start;
    assign adv  = !out_valid || out_ready;
    assign gen  = (state == RUN) && adv;

    // Raster index doubles as the (u,v) counter: flipping the MSB of each field offsets by -GRID/2.
    assign u = {~idx_r[UW-1], idx_r[UW-2:0]};
    assign v = {~idx_r[IW-1], idx_r[IW-2:UW]};

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (adv && idx_r == LAST_IDX) state_nxt = DRAIN;
            DRAIN: if (out_valid && out_ready && out_idx == LAST_IDX) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            idx_r <= '0;
            cos_r <= '0;
            sin_r <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (gen) idx_r <= idx_r + 1'b1;
            if (load) begin
                cos_r <= cos_nxt;
                sin_r <= sin_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_idx  <= '0;
            s1_ucos <= '0;
            s1_vsin <= '0;
            s1_usin <= '0;
            s1_vcos <= '0;
        end else if (adv) begin
            s1_vld  <= (state == RUN);
            s1_idx  <= idx_r;
            s1_ucos <= PW'(u) * PW'(cos_r);
            s1_vsin <= PW'(v) * PW'(sin_r);
            s1_usin <= PW'(u) * PW'(sin_r);
            s1_vcos <= PW'(v) * PW'(cos_r);
        end
    end

    // +64 before the arithmetic shift rounds half up.
    assign sum_x = SW'(s1_ucos) - SW'(s1_vsin) + SW'(64);
    assign sum_y = SW'(s1_usin) + SW'(s1_vcos) + SW'(64);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_idx <= s1_idx;
                out_x   <= OW'(sum_x >>> 7);
                out_y   <= OW'(sum_y >>> 7);
            end
        end
    end

endmodule

// File: tb/tb_dir_rot_sample_gen.sv
// Directed/randomized bench for dir_rot_sample_gen against a rotation-formula reference model.
module tb_dir_rot_sample_gen;
    localparam int GRID  = 16;
    localparam int OW    = $clog2(GRID) + 2;
    localparam int IW    = $clog2(GRID * GRID);
    localparam int NS    = GRID * GRID;
    localparam int LIMIT = 3000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [4:0]           dir = 5'd0;
    logic                 busy, out_valid, done;
    logic signed [OW-1:0] out_x, out_y;
    logic [IW-1:0]        out_idx;

    int checks = 0;
    int failures = 0;
    int ctab[0:8] = '{128, 126, 118, 106, 91, 71, 49, 25, 0};

    always #5 clk = ~clk;

    dir_rot_sample_gen #(.GRID(GRID)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_idx(out_idx), .done(done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rotate the k-th raster offset by bin d; floor((a + 64) / 128) rounds half up.
    function automatic void model(input int d, input int k, output int x, output int y);
        int q, r, c, s, u, v;
        q = d / 8;
        r = d % 8;
        case (q)
            0:       begin c =  ctab[r];     s =  ctab[8 - r]; end
            1:       begin c = -ctab[8 - r]; s =  ctab[r];     end
            2:       begin c = -ctab[r];     s = -ctab[8 - r]; end
            default: begin c =  ctab[8 - r]; s = -ctab[r];     end
        endcase
        u = k % GRID - GRID / 2;
        v = k / GRID - GRID / 2;
        x = (u * c - v * s + 64) >>> 7;
        y = (u * s + v * c + 64) >>> 7;
    endfunction

    // Called at a negedge; returns at a negedge. n counts negedges after the start edge E0.
    task automatic run_job(input int d, input bit rnd, input bit noise, input bit chain,
                           input int chain_d, input bit pre,
                           output int fx, output int fy, output int lx, output int ly,
                           output int first_n, output int acc_n);
        int cnt, ex, ey, px, py, pidx, w;
        bit stall, fin;
        if (!pre) begin
            w = 0;
            while (busy && w < LIMIT) begin @(negedge clk); w++; end
            check("idle_before_start", busy, 0);
            start = 1'b1;
            dir   = d[4:0];
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_low_at_start", done, 0);
        cnt = 0; stall = 0; fin = 0; first_n = -1; acc_n = -1;
        fx = 0; fy = 0; lx = 0; ly = 0; px = 0; py = 0; pidx = 0;
        for (int n = 0; n < LIMIT && !fin; n++) begin
            if (n > 0) @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise && n == 50) begin start = 1'b1; dir = d[4:0] ^ 5'h11; end
            if (noise && n == 51) begin start = 1'b0; dir = d[4:0]; end
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_x", out_x, px);
                check("stall_y", out_y, py);
                check("stall_idx", out_idx, pidx);
            end
            if (acc_n >= 0) begin
                check("done_pulse", done, 1);
                check("busy_drop", busy, 0);
                check("valid_after_last", out_valid, 0);
                fin = 1;
                if (chain) begin start = 1'b1; dir = chain_d[4:0]; end
            end else begin
                check("done_early", done, 0);
                if (out_valid && first_n < 0) first_n = n;
                if (out_valid && out_ready) begin
                    model(d, cnt, ex, ey);
                    check("idx", out_idx, cnt);
                    check("x", out_x, ex);
                    check("y", out_y, ey);
                    if (cnt == 0) begin fx = out_x; fy = out_y; end
                    if (cnt == NS - 1) begin lx = out_x; ly = out_y; acc_n = n; end
                    cnt++;
                end
                stall = out_valid && !out_ready;
                px = out_x; py = out_y; pidx = out_idx;
            end
        end
        check("job_finished", fin, 1);
        if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int fx, fy, lx, ly, fn, an, cnt, n, d;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_x", out_x, 0);
        check("rst_y", out_y, 0);
        check("rst_idx", out_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(0, 0, 0, 0, 0, 0, fx, fy, lx, ly, fn, an);
        check("d0_first_x", fx, -8);
        check("d0_first_y", fy, -8);
        check("d0_last_x", lx, 7);
        check("d0_last_y", ly, 7);
        check("d0_latency", fn, 2);
        check("d0_last_beat", an, 2 + NS - 1);

        run_job(8, 0, 0, 0, 0, 0, fx, fy, lx, ly, fn, an);
        check("d8_first_x", fx, 8);
        check("d8_first_y", fy, -8);
        check("d8_last_x", lx, -7);
        check("d8_last_y", ly, 7);

        run_job(16, 0, 0, 0, 0, 0, fx, fy, lx, ly, fn, an);
        check("d16_first_x", fx, 8);
        check("d16_first_y", fy, 8);

        run_job(4, 0, 0, 0, 0, 0, fx, fy, lx, ly, fn, an);
        check("d4_first_x", fx, 0);
        check("d4_first_y", fy, -11);
        check("d4_last_x", lx, 0);
        check("d4_last_y", ly, 10);

        run_job(23, 1, 0, 0, 0, 0, fx, fy, lx, ly, fn, an);

        // Start pulse with another dir mid-job, then a chained start in the done cycle.
        run_job(23, 0, 1, 1, 11, 0, fx, fy, lx, ly, fn, an);
        run_job(11, 0, 0, 0, 0, 1, fx, fy, lx, ly, fn, an);
        check("chain_latency", fn, 2);
        check("chain_last_beat", an, 2 + NS - 1);

        // Asynchronous reset in the middle of a job.
        start = 1'b1; dir = 5'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        cnt = 0; n = 0;
        while (cnt < 100 && n < LIMIT) begin
            if (out_valid && out_ready) cnt++;
            @(negedge clk);
            n++;
        end
        check("pre_reset_count", cnt, 100);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_idx", out_idx, 0);
        check("midrst_x", out_x, 0);
        @(negedge clk);
        check("midrst_no_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(5, 0, 0, 0, 0, 0, fx, fy, lx, ly, fn, an);
        check("post_rst_latency", fn, 2);

        for (int j = 0; j < 3; j++) begin
            d = int'($urandom_range(0, 31));
            run_job(d, 1, 0, 0, 0, 0, fx, fy, lx, ly, fn, an);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
